// File: rtl/demux_1to2_64_buf.sv
// One-to-two demultiplexer with an independent DEPTH-entry FIFO per output.
// Upstream backpressure comes only from the FIFO that i_select addresses.
module demux_1to2_64_buf #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic                     i_select,
    input  logic [63:0]              i_data,
    output logic                     o_ready,
    output logic                     o_valid_a,
    output logic                     o_valid_b,
    output logic [63:0]              o_data_a,
    output logic [63:0]              o_data_b,
    input  logic                     i_ready_a,
    input  logic                     i_ready_b,
    output logic [$clog2(DEPTH):0]   o_count_a,
    output logic [$clog2(DEPTH):0]   o_count_b
);

    localparam int DATA_W = 64;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Index 0 is output A, index 1 is output B.
    logic [DATA_W-1:0] mem [2][DEPTH];
    logic [PW-1:0]     rd_ptr [2];
    logic [PW-1:0]     wr_ptr [2];
    logic [CW-1:0]     count  [2];
    logic [1:0]        full;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        rdy;

    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                                  input logic          psh,
                                                  input logic          pp);
        logic [CW-1:0] nxt;
        nxt = cnt;
        if (psh && !pp)
            nxt = cnt + CW'(1);
        else if (pp && !psh)
            nxt = cnt - CW'(1);
        return nxt;
    endfunction

    assign rdy = {i_ready_b, i_ready_a};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            full[c] = (count[c] == FULL_CNT);
            pop[c]  = !reset && (count[c] != '0) && rdy[c];
        end
        o_ready = !reset && !full[i_select];
        push[0] = i_valid && o_ready && !i_select;
        push[1] = i_valid && o_ready &&  i_select;
    end

    // Control state: pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c])
                    wr_ptr[c] <= wr_ptr[c] + PW'(1);
                if (pop[c])
                    rd_ptr[c] <= rd_ptr[c] + PW'(1);
                count[c] <= next_count(count[c], push[c], pop[c]);
            end
        end
    end

    // Storage: left unreset, the head is masked to zero while empty
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c])
                mem[c][wr_ptr[c]] <= i_data;
        end
    end

    assign o_count_a = count[0];
    assign o_count_b = count[1];
    assign o_valid_a = (count[0] != '0);
    assign o_valid_b = (count[1] != '0);
    assign o_data_a  = o_valid_a ? mem[0][rd_ptr[0]] : '0;
    assign o_data_b  = o_valid_b ? mem[1][rd_ptr[1]] : '0;

endmodule

// File: tb/tb_demux_1to2_64_buf.sv
// Bench for demux_1to2_64_buf: directed scenarios plus random traffic,
// all checked against a queue-based model of the two output FIFOs.
module tb_demux_1to2_64_buf;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid;
    logic          i_select;
    logic [63:0]   i_data;
    logic          o_ready;
    logic          o_valid_a;
    logic          o_valid_b;
    logic [63:0]   o_data_a;
    logic [63:0]   o_data_b;
    logic          i_ready_a;
    logic          i_ready_b;
    logic [CW-1:0] o_count_a;
    logic [CW-1:0] o_count_b;

    always #5 clk = ~clk;

    demux_1to2_64_buf #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .i_select  (i_select),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .o_valid_a (o_valid_a),
        .o_valid_b (o_valid_b),
        .o_data_a  (o_data_a),
        .o_data_b  (o_data_b),
        .i_ready_a (i_ready_a),
        .i_ready_b (i_ready_b),
        .o_count_a (o_count_a),
        .o_count_b (o_count_b)
    );

    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [63:0] got_a[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        e_push_a, e_push_b, e_pop_a, e_pop_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs and compare every output against the model.
    task automatic step(input logic rst, input logic v, input logic sel,
                        input logic [63:0] d, input logic ra, input logic rb);
        logic        e_ready;
        logic [63:0] e_head_a, e_head_b;
        reset     = rst;
        i_valid   = v;
        i_select  = sel;
        i_data    = d;
        i_ready_a = ra;
        i_ready_b = rb;
        #1;
        e_ready  = !rst && (sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
        e_push_a = v && e_ready && !sel;
        e_push_b = v && e_ready &&  sel;
        e_pop_a  = !rst && (qa.size() > 0) && ra;
        e_pop_b  = !rst && (qb.size() > 0) && rb;
        e_head_a = 64'd0;
        e_head_b = 64'd0;
        if (qa.size() > 0) e_head_a = qa[0];
        if (qb.size() > 0) e_head_b = qb[0];
        chk("o_ready",   64'(o_ready),   64'(e_ready));
        chk("valid_a",   64'(o_valid_a), 64'(qa.size() > 0));
        chk("valid_b",   64'(o_valid_b), 64'(qb.size() > 0));
        chk("count_a",   64'(o_count_a), 64'(qa.size()));
        chk("count_b",   64'(o_count_b), 64'(qb.size()));
        chk("data_a",    o_data_a,       e_head_a);
        chk("data_b",    o_data_b,       e_head_b);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            qa.delete();
            qb.delete();
        end else begin
            if (e_pop_a)  void'(qa.pop_front());
            if (e_pop_b)  void'(qb.pop_front());
            if (e_push_a) qa.push_back(i_data);
            if (e_push_b) qb.push_back(i_data);
        end
        @(negedge clk);
    endtask

    task automatic cyc(input logic rst, input logic v, input logic sel,
                       input logic [63:0] d, input logic ra, input logic rb);
        step(rst, v, sel, d, ra, rb);
        tick();
    endtask

    initial begin
        reset = 1'b1; i_valid = 1'b0; i_select = 1'b0; i_data = '0;
        i_ready_a = 1'b0; i_ready_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, including o_ready held low during reset
        step(1'b1, 1'b1, 1'b0, 64'h55, 1'b1, 1'b1);
        chk("rst_ready", 64'(o_ready), 64'd0);
        tick();

        // Single word to each output
        cyc(1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 64'h2, 1'b0, 1'b0);
        chk("s1_valid_a", 64'(o_valid_a), 64'd1);
        chk("s1_data_a",  o_data_a, 64'hDEAD_BEEF_0000_0001);
        chk("s1_valid_b_latency", 64'(o_valid_b), 64'd0);
        tick();
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("s1_data_b",  o_data_b, 64'd2);
        chk("s1_count_a", 64'(o_count_a), 64'd1);
        chk("s1_count_b", 64'(o_count_b), 64'd1);
        tick();

        // Full FIFO A holds word 3 until i_select moves to B
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 64'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 64'd3, 1'b0, 1'b0);
        chk("full_ready", 64'(o_ready),   64'd0);
        chk("full_count", 64'(o_count_a), 64'd2);
        tick();
        step(1'b0, 1'b1, 1'b1, 64'd3, 1'b0, 1'b0);
        chk("sel_switch_ready", 64'(o_ready), 64'd1);
        tick();
        step(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        chk("full_head_a", o_data_a, 64'd1);
        tick();

        // Order and wrap with simultaneous push/pop
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 64'(i), 1'b1, 1'b0);
            if (i > 1) begin
                chk("stream_count", 64'(o_count_a), 64'd1);
                chk("stream_data",  o_data_a, 64'(i - 1));
            end
            tick();
        end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        chk("stream_last", o_data_a, 64'd10);
        tick();

        // Stalled B must not block A
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        got_a.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 64'(100 + i), 1'b1, 1'b0);
            if (i >= 2) chk("indep_ready_b_full", 64'(o_ready), 64'd0);
            if (o_valid_a) got_a.push_back(o_data_a);
            tick();
            step(1'b0, 1'b1, 1'b0, 64'(200 + i), 1'b1, 1'b0);
            chk("indep_ready_a", 64'(o_ready), 64'd1);
            if (o_valid_a) got_a.push_back(o_data_a);
            tick();
        end
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        if (o_valid_a) got_a.push_back(o_data_a);
        chk("indep_count_b", 64'(o_count_b), 64'd2);
        chk("indep_head_b",  o_data_b, 64'd100);
        tick();
        chk("indep_n_a", 64'(got_a.size()), 64'd5);
        for (int i = 0; i < got_a.size() && i < 5; i++)
            chk("indep_order_a", got_a[i], 64'(200 + i));

        // Reset mid-stream discards stored words
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 64'h11, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 64'h12, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 64'h13, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("mid_count_a_before", 64'(o_count_a), 64'd2);
        tick();
        step(1'b0, 1'b1, 1'b1, 64'h7, 1'b0, 1'b0);
        chk("mid_valid_a", 64'(o_valid_a), 64'd0);
        chk("mid_valid_b", 64'(o_valid_b), 64'd0);
        chk("mid_count_b", 64'(o_count_b), 64'd0);
        tick();
        step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("mid_data_b", o_data_b, 64'd7);
        tick();

        // Random traffic against the model
        repeat (3000) begin
            cyc(($urandom % 64) == 0, 1'($urandom % 2), 1'($urandom % 2),
                {$urandom, $urandom}, ($urandom % 4) != 0, ($urandom % 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
